// File: rtl/pdr_pkg.sv
// Shared types and default sizing for the parallel data receiver.
package pdr_pkg;

  localparam int PDR_WIDTH = 4;
  localparam int PDR_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } pdr_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parallel_data_receiver.sv
// 4-phase bundled-data receiver feeding a first-word-fall-through buffer.
// Optional even-parity check on captured words when PDR_PARITY_EN is defined.
module parallel_data_receiver
  import pdr_pkg::*;
#(
  parameter int WIDTH = PDR_WIDTH,
  parameter int DEPTH = PDR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [WIDTH-1:0]         data_in,
`ifdef PDR_PARITY_EN
  input  logic                     parity_in,
  output logic                     parity_err,
`endif
  output logic                     ack_out,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic             req_s;
  pdr_state_e       state, state_next;
  logic             capture;
  logic             parity_ok;
  logic             do_write, do_pop;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] last_word;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_in),
    .q   (req_s)
  );

`ifdef PDR_PARITY_EN
  assign parity_ok = (parity_in == ^data_in);
`else
  assign parity_ok = 1'b1;
`endif

  // The full check uses the pre-edge count, so a pop on the same edge only unblocks next cycle.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE:    if (req_s && (count != FULL_COUNT)) state_next = CAPTURE;
      CAPTURE: begin
        capture    = 1'b1;
        state_next = ACK;
      end
      ACK:     if (!req_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign do_write  = capture && parity_ok && (count != FULL_COUNT);
  assign do_pop    = rd_en && (count != '0);
  assign valid_out = (count != '0);
  assign data_out  = valid_out ? mem[rd_ptr] : last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ack_out <= 1'b0;
    end else begin
      state   <= state_next;
      ack_out <= (state_next == ACK);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_in;
  end

  // last_word keeps the most recently popped word visible once the buffer drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_word <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_word <= mem[rd_ptr];
      end
      case ({do_write, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (rd_en && (count == '0)) underflow <= 1'b1;
    end
  end

`ifdef PDR_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= capture && !parity_ok;
  end
`endif

endmodule

// File: tb/tb_parallel_data_receiver.sv
// Scoreboard bench for parallel_data_receiver; PDR_PARITY_EN adds the parity scenario.
module tb_parallel_data_receiver;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             rd_en = 1'b0;
  logic             ack_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic [CW-1:0]    count;
  logic             underflow;
`ifdef PDR_PARITY_EN
  logic             parity_in = 1'b0;
  logic             parity_err;
`endif

  int compared   = 0;
  int mismatched = 0;
  int pops_seen  = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_uflow = 1'b0;

  parallel_data_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .data_in    (data_in),
`ifdef PDR_PARITY_EN
    .parity_in  (parity_in),
    .parity_err (parity_err),
`endif
    .ack_out    (ack_out),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .count      (count),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: model is a plain queue of accepted words plus a sticky underflow bit.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("count_model", 32'(count), 32'(model_q.size()));
      checkOutput("valid_model", 32'(valid_out), 32'(model_q.size() != 0));
      checkOutput("underflow_model", 32'(underflow), 32'(model_uflow));
      checkOutput("count_bound", 32'(32'(count) <= DEPTH), 32'(1));
      if (model_q.size() != 0)
        checkOutput("head_word", 32'(data_out), 32'(model_q[0]));
      if (rd_en) begin
        if (model_q.size() == 0) begin
          model_uflow = 1'b1;
          if (valid_out) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL pop_unexpected: actual=%0h expected=no word", data_out);
          end
        end else begin
          checkOutput("fifo_order", 32'(data_out), 32'(model_q.pop_front()));
          pops_seen++;
        end
      end
    end
  end

  task automatic resetDut();
    rst     = 1'b1;
    req_in  = 1'b0;
    rd_en   = 1'b0;
    model_q.delete();
    model_uflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic raiseReq(input logic [WIDTH-1:0] w);
    data_in = w;
`ifdef PDR_PARITY_EN
    parity_in = ^w;
`endif
    req_in = 1'b1;
  endtask

  task automatic waitAck(input string name, input logic [WIDTH-1:0] w, input bit push);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (ack_out) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeoutFail(name);
    else if (push) model_q.push_back(w);
  endtask

  task automatic dropReq(input string name);
    bit seen = 1'b0;
    req_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!ack_out) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeoutFail(name);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] w);
    raiseReq(w);
    waitAck("ack_rise", w, 1'b1);
    dropReq("ack_fall");
  endtask

  task automatic popOne();
    @(posedge clk);
    #1;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic randomReader(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (pops_seen >= target) break;
      rd_en = 1'($urandom_range(0, 1));
    end
    rd_en = 1'b0;
    if (pops_seen < target) timeoutFail("reader_drain");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int target;

    // Reset values
    resetDut();
    checkOutput("rst_ack", 32'(ack_out), 32'(0));
    checkOutput("rst_valid", 32'(valid_out), 32'(0));
    checkOutput("rst_count", 32'(count), 32'(0));
    checkOutput("rst_data", 32'(data_out), 32'(0));
    checkOutput("rst_underflow", 32'(underflow), 32'(0));
`ifdef PDR_PARITY_EN
    checkOutput("rst_parity_err", 32'(parity_err), 32'(0));
`endif

    // Handshake latency: req first sampled at edge N, results visible after N+3
    raiseReq(4'hA);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("lat_ack_early", 32'(ack_out), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("lat_ack", 32'(ack_out), 32'(1));
    if (ack_out) model_q.push_back(4'hA);
    checkOutput("lat_valid", 32'(valid_out), 32'(1));
    checkOutput("lat_data", 32'(data_out), 32'hA);
    checkOutput("lat_count", 32'(count), 32'(1));
    dropReq("lat_drop");
    popOne();
    checkOutput("empty_hold_data", 32'(data_out), 32'hA);

    // Backpressure at full, unblocked one cycle after the pop edge
    resetDut();
    for (int i = 1; i <= 4; i++) applyStimulus(WIDTH'(i));
    checkOutput("full_count", 32'(count), 32'(4));
    raiseReq(4'h5);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("bp_ack_withheld", 32'(ack_out), 32'(0));
    checkOutput("bp_count", 32'(count), 32'(4));
    popOne();
    checkOutput("bp_after_pop_ack", 32'(ack_out), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("bp_not_yet", 32'(ack_out), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("bp_resume_ack", 32'(ack_out), 32'(1));
    if (ack_out) model_q.push_back(4'h5);
    else waitAck("bp_resume", 4'h5, 1'b1);
    dropReq("bp_drop");
    repeat (4) popOne();

    // Concurrent read/write across pointer wrap
    resetDut();
    for (int i = 1; i <= 4; i++) applyStimulus(WIDTH'(i));
    target = pops_seen + 8;
    fork
      begin
        for (int i = 6; i <= 9; i++) applyStimulus(WIDTH'(i));
      end
      randomReader(target, 400);
    join

    // Underflow is sticky until reset
    resetDut();
    popOne();
    checkOutput("uf_set", 32'(underflow), 32'(1));
    checkOutput("uf_count", 32'(count), 32'(0));
    applyStimulus(4'h2);
    popOne();
    checkOutput("uf_sticky", 32'(underflow), 32'(1));

    // Early request drops: a sampled pulse captures once, an unsampled glitch captures nothing
    resetDut();
    raiseReq(4'h6);
    @(posedge clk);
    #1;
    req_in = 1'b0;
    waitAck("early_drop_ack", 4'h6, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("early_drop_count", 32'(count), 32'(1));
    req_in = 1'b1;
    #2;
    req_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("glitch_count", 32'(count), 32'(1));
    checkOutput("glitch_ack", 32'(ack_out), 32'(0));

    // Reset while in ACK with two words buffered
    resetDut();
    applyStimulus(4'h7);
    raiseReq(4'hB);
    waitAck("mid_ack", 4'hB, 1'b1);
    checkOutput("mid_count", 32'(count), 32'(2));
    rst     = 1'b1;
    req_in  = 1'b0;
    model_q.delete();
    model_uflow = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_ack", 32'(ack_out), 32'(0));
    checkOutput("mid_rst_count", 32'(count), 32'(0));
    checkOutput("mid_rst_valid", 32'(valid_out), 32'(0));
    rst = 1'b0;
    applyStimulus(4'hC);
    checkOutput("post_rst_data", 32'(data_out), 32'hC);
    popOne();

`ifdef PDR_PARITY_EN
    // Parity mismatch: no write, one-cycle error pulse, handshake still completes
    resetDut();
    raiseReq(4'h3);
    parity_in = 1'b1;
    waitAck("par_ack", 4'h3, 1'b0);
    checkOutput("par_err_pulse", 32'(parity_err), 32'(1));
    checkOutput("par_count", 32'(count), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("par_err_clear", 32'(parity_err), 32'(0));
    dropReq("par_drop");
`endif

    // Randomized traffic against the queue model
    resetDut();
    target = pops_seen + 16;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          applyStimulus(WIDTH'($urandom_range(0, 15)));
        end
      end
      randomReader(target, 2000);
    join
    @(posedge clk);
    #1;
    checkOutput("rand_drained", 32'(count), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
